// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS IF stage: opcodes, fetch FSM states and
// the redirect target helpers used by the fetch stage.
package fetch_stage_pkg;

    localparam logic [5:0]  INS_J             = 6'h02;
    localparam logic [5:0]  INS_JAL           = 6'h03;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

    // Conditional-branch target: PC+4 plus the sign-extended word offset.
    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [15:0] imm);
        return pc4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // j/jal target: region bits of PC+4 concatenated with the instruction index.
    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [25:0] idx);
        return {pc4[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC, instruction-memory handshake,
// one-entry hold buffer for load-use stalls and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        remain_pc,
    input  logic        id_branch,
    input  logic        id_jump,
    input  logic        id_jal,
    input  logic        id_jr,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    fetch_state_e state_r;
    logic         hold_valid_r;
    logic [31:0]  hold_instr_r;
    logic [31:0]  hold_pc4_r;
    logic [31:0]  pending_pc_r;

    logic         redirect_s;
    logic         fire_s;
    logic [31:0]  target_s;
    logic [31:0]  pc_plus4_s;

    assign redirect_s = id_branch & ~remain_pc & if_id_valid;
    assign fire_s     = imem_req & imem_ready;
    assign pc_plus4_s = pc + 32'd4;
    assign imem_addr  = {pc[31:2], 2'b00};

    // Redirect target for the instruction currently held in IF/ID.
    always_comb begin
        target_s = 32'h0000_0000;
        if (id_jr) begin
            target_s = id_rs_val;
        end else if (id_jump || id_jal) begin
            target_s = jump_target(if_id_pc4, if_id_instr[25:0]);
        end else begin
            target_s = branch_target(if_id_pc4, if_id_instr[15:0]);
        end
    end

    // Fetch FSM with PC, hold buffer and IF/ID register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            if_id_instr  <= NOP_INSTR;
            if_id_pc4    <= 32'h0000_0000;
            if_id_valid  <= 1'b0;
            hold_valid_r <= 1'b0;
            hold_instr_r <= NOP_INSTR;
            hold_pc4_r   <= 32'h0000_0000;
            pending_pc_r <= RESET_PC;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r  <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (fire_s) begin
                        if (redirect_s) begin
                            pc          <= target_s;
                            if_id_instr <= NOP_INSTR;
                            if_id_valid <= 1'b0;
                        end else if (remain_pc) begin
                            // ID is frozen: park the word and stop requesting until it drains.
                            hold_instr_r <= imem_rdata;
                            hold_pc4_r   <= pc_plus4_s;
                            hold_valid_r <= 1'b1;
                            pc           <= pc_plus4_s;
                            imem_req     <= 1'b0;
                        end else begin
                            if_id_instr <= imem_rdata;
                            if_id_pc4   <= pc_plus4_s;
                            if_id_valid <= 1'b1;
                            pc          <= pc_plus4_s;
                        end
                    end else if (imem_req) begin
                        if (redirect_s) begin
                            pending_pc_r <= target_s;
                            if_id_instr  <= NOP_INSTR;
                            if_id_valid  <= 1'b0;
                            state_r      <= ST_DROP;
                        end else if (!remain_pc) begin
                            if_id_instr <= NOP_INSTR;
                            if_id_valid <= 1'b0;
                        end else begin
                            if_id_valid <= if_id_valid;
                        end
                    end else begin
                        // No request in flight: the hold buffer is waiting to drain.
                        if (redirect_s) begin
                            pc           <= target_s;
                            hold_valid_r <= 1'b0;
                            if_id_instr  <= NOP_INSTR;
                            if_id_valid  <= 1'b0;
                            imem_req     <= 1'b1;
                        end else if (!remain_pc) begin
                            if_id_instr  <= hold_valid_r ? hold_instr_r : NOP_INSTR;
                            if_id_pc4    <= hold_valid_r ? hold_pc4_r : if_id_pc4;
                            if_id_valid  <= hold_valid_r;
                            hold_valid_r <= 1'b0;
                            imem_req     <= 1'b1;
                        end else begin
                            hold_valid_r <= hold_valid_r;
                        end
                    end
                end
                ST_DROP: begin
                    // The stale response must still be accepted before the new address goes out.
                    if (fire_s) begin
                        pc      <= redirect_s ? target_s : pending_pc_r;
                        state_r <= ST_FETCH;
                    end else if (redirect_s) begin
                        pending_pc_r <= target_s;
                    end else begin
                        pending_pc_r <= pending_pc_r;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
